ps2_keypad: RTL and testbench
=============================

// Module: ps2_keypad
// PURPOSE
//  PS/2 keyboard receiver and key-state tracker: produces the held-key bitmap keydown[4:0] consumed by the Mario controller.
//  - Deserialises PS/2 device-to-host frames.
//  - Interprets E0 (extended) and F0 (break) prefixes.
//  - Keeps one held/released bit per game key.
//  - Sits between the board PS/2 pins and the game logic; one system clock domain.
// PARAMETERS
//  FILTER_LEN   8      consecutive equal samples of synced ps2_clk needed to accept a new level
//  TIMEOUT_CYC  50000  clk cycles with no ps2_clk falling edge mid-frame before the frame is aborted
// PORTS
//  clk         in   1  system clock
//  rst         in   1  asynchronous active-high reset
//  ps2_clk     in   1  raw PS/2 clock pin (asynchronous)
//  ps2_data    in   1  raw PS/2 data pin (asynchronous)
//  keydown     out  5  held keys: [0]=up, [1]=left, [2]=right, [3]=down, [4]=jump
//  scan_valid  out  1  one-cycle pulse when a good byte is received
//  scan_code   out  8  last good byte; held between pulses
//  frame_err   out  1  one-cycle pulse on a parity/stop error or a timeout
// BEHAVIOUR
//  Reset: all outputs, counters, prefix flags and the FSM go to 0/IDLE immediately; reset mid-frame discards that frame.
//  Input conditioning:
//  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//  - ps2_clk is then filtered: level changes only after FILTER_LEN identical samples.
//  - fall = filtered ps2_clk 1->0; ps2_data (synced) is sampled on that cycle.
//  Frame FSM (advances only on fall):
//  - IDLE: sampled 0 -> DATA with bit count 0; sampled 1 -> stay IDLE (glitch).
//  - DATA: shift in LSB first; after 8 bits -> PARITY.
//  - PARITY: store bit -> STOP.
//  - STOP: stop=1 and odd parity over data+parity good -> accept byte; otherwise frame_err. Either way -> IDLE.
//  - Timeout: in any state except IDLE, TIMEOUT_CYC clk cycles with no fall -> frame_err, back to IDLE. The counter clears on each fall.
//  Latency: scan_valid, scan_code and any keydown change appear on the clk edge after the stop-bit fall is seen, all in the same cycle.
//  Decoder, per accepted byte:
//  - E0: set ext.
//  - F0: set brk.
//  - Any other byte: look up (ext, code).
//    - Mapped: set the key bit if brk=0, clear it if brk=1.
//    - Unmapped: no keydown change.
//    - Then clear ext and brk.
//  - scan_valid pulses for every accepted byte, prefixes included.
//  Key map:
//  - up = E0 75, left = E0 6B, right = E0 74, down = E0 72.
//  - jump = 29 (space, non-extended).
//  - Non-extended 75/6B/74/72 (keypad) are unmapped.
//  Boundaries:
//  - frame_err clears ext and brk; keydown is unchanged.
//  - Repeated make codes (typematic) leave the bit set.
//  - A break for a key not held leaves the bit clear.
//  - Keys are independent: several bits may be 1 at once, including both left and right.
//  - A repeated F0 or E0 simply keeps its flag set.
// CONFIGURATION
//  KEYPAD_WASD_EN defined:
//  - Adds non-extended aliases: 1D=up, 1C=left, 23=right, 1B=down.
//  - Each alias drives the same bit as its arrow key, and either make sets the bit.
//  - Either break clears the bit: no per-source tracking.
//  KEYPAD_WASD_EN undefined: 1D/1C/23/1B are unmapped; arrows and space only.
// TESTING
//  1 Assert rst mid-frame (after 4 data bits) with keydown=5'b10000.
//    -> keydown=0, no scan_valid or frame_err; a following good frame 29 decodes normally.
//  2 Send frames E0, 75 (parity bits 0, 0).
//    -> two scan_valid pulses, scan_code=75, keydown=5'b00001 on the cycle after the second stop fall.
//  3 Send E0, F0, 75 after case 2.
//    -> keydown=0; then 29 -> 5'b10000; then F0, 29 -> 0.
//  4 Send 29 with parity bit 1 (wrong).
//    -> frame_err pulse, no scan_valid, keydown unchanged.
//    Also: E0, then a bad frame, then 75 -> 75 is treated as non-extended, so keydown is unchanged.
//  5 Stop clocking after 3 data bits for TIMEOUT_CYC+1 cycles.
//    -> exactly one frame_err, FSM back in IDLE; the next good frame E0, 6B gives keydown=5'b00010.
//  6 With KEYPAD_WASD_EN: send 1C, then E0 74.
//    -> keydown=5'b00110; F0 1C -> 5'b00100.
//    Without the macro: 1C gives a scan_valid pulse but keydown stays 0.

Source files
------------

// File: rtl/ps2_keypad.sv
// ps2_keypad: PS/2 receiver with E0/F0 prefix decoding into a held-key bitmap; define KEYPAD_WASD_EN to add WASD aliases
module ps2_keypad #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [4:0] keydown,
   output logic       scan_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic [1:0]    cs_q, ds_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] fc_q, fc_d;
   logic [1:0]    st_q, st_d;
   logic [7:0]    sh_q, sh_d;
   logic [2:0]    bc_q, bc_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_q, to_d;
   logic          ext_q, ext_d, brk_q, brk_d;
   logic [4:0]    kd_q, kd_d;
   logic          sv_q, fe_q;
   logic [7:0]    sc_q, sc_d;
   logic          fall, din, tmo, last, frame_ok, good, bad, pfx;
   logic [4:0]    mask, alias_mask;

   // ps2_clk glitch filter: flip only after FILTER_LEN consecutive differing samples
   always_comb begin
      fc_d   = (cs_q[1] == filt_q || fc_q == FW'(FILTER_LEN - 1)) ? '0 : fc_q + 1'b1;
      filt_d = (cs_q[1] != filt_q && fc_q == FW'(FILTER_LEN - 1)) ? cs_q[1] : filt_q;
      fall   = filt_q & ~filt_d;
      din    = ds_q[1];
   end

   // frame FSM, advancing on filtered falling edges, aborted by a mid-frame timeout
   always_comb begin
      tmo      = (st_q != IDLE) && !fall && (to_q == TW'(TIMEOUT_CYC - 1));
      last     = fall && (st_q == STOP);
      frame_ok = din && ^{sh_q, par_q};
      good     = last && frame_ok;
      bad      = (last && !frame_ok) || tmo;
      st_d     = tmo ? IDLE :
                 !fall ? st_q :
                 (st_q == IDLE) ? (din ? IDLE : DATA) :
                 (st_q == DATA) ? ((bc_q == 3'd7) ? PARITY : DATA) :
                 (st_q == PARITY) ? STOP : IDLE;
      sh_d     = (fall && st_q == DATA) ? {din, sh_q[7:1]} : sh_q;
      bc_d     = (fall && st_q == IDLE) ? 3'd0 : (fall && st_q == DATA) ? bc_q + 3'd1 : bc_q;
      par_d    = (fall && st_q == PARITY) ? din : par_q;
      to_d     = (st_q == IDLE || fall || tmo) ? '0 : to_q + 1'b1;
   end

   // byte decoder: prefix flags and key bitmap updates
   always_comb begin
`ifdef KEYPAD_WASD_EN
      alias_mask = (sh_q == 8'h1D) ? 5'b00001 :
                   (sh_q == 8'h1C) ? 5'b00010 :
                   (sh_q == 8'h23) ? 5'b00100 :
                   (sh_q == 8'h1B) ? 5'b01000 : 5'b00000;
`else
      alias_mask = 5'b00000;
`endif
      mask  = ext_q ? ((sh_q == 8'h75) ? 5'b00001 :
                       (sh_q == 8'h6B) ? 5'b00010 :
                       (sh_q == 8'h74) ? 5'b00100 :
                       (sh_q == 8'h72) ? 5'b01000 : 5'b00000)
                    : ((sh_q == 8'h29) ? 5'b10000 : alias_mask);
      pfx   = (sh_q == 8'hE0) || (sh_q == 8'hF0);
      kd_d  = (good && !pfx) ? (brk_q ? (kd_q & ~mask) : (kd_q | mask)) : kd_q;
      ext_d = bad ? 1'b0 : good ? ((sh_q == 8'hE0) ? 1'b1 : (sh_q == 8'hF0) ? ext_q : 1'b0) : ext_q;
      brk_d = bad ? 1'b0 : good ? ((sh_q == 8'hF0) ? 1'b1 : (sh_q == 8'hE0) ? brk_q : 1'b0) : brk_q;
      sc_d  = good ? sh_q : sc_q;
   end

   // state registers; pins and filter idle high so reset never fakes a falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q   <= 2'b11;
         ds_q   <= 2'b11;
         filt_q <= 1'b1;
         fc_q   <= '0;
         st_q   <= IDLE;
         sh_q   <= '0;
         bc_q   <= '0;
         par_q  <= 1'b0;
         to_q   <= '0;
         ext_q  <= 1'b0;
         brk_q  <= 1'b0;
         kd_q   <= '0;
         sv_q   <= 1'b0;
         fe_q   <= 1'b0;
         sc_q   <= '0;
      end else begin
         cs_q   <= {cs_q[0], ps2_clk};
         ds_q   <= {ds_q[0], ps2_data};
         filt_q <= filt_d;
         fc_q   <= fc_d;
         st_q   <= st_d;
         sh_q   <= sh_d;
         bc_q   <= bc_d;
         par_q  <= par_d;
         to_q   <= to_d;
         ext_q  <= ext_d;
         brk_q  <= brk_d;
         kd_q   <= kd_d;
         sv_q   <= good;
         fe_q   <= bad;
         sc_q   <= sc_d;
      end
   end

   assign keydown    = kd_q;
   assign scan_valid = sv_q;
   assign scan_code  = sc_q;
   assign frame_err  = fe_q;
endmodule

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad: directed PS/2 frame bench for ps2_keypad
module tb_ps2_keypad;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [4:0] keydown;
   logic       scan_valid;
   logic [7:0] scan_code;
   logic       frame_err;
   int checks = 0;
   int errors = 0;
   int sv_cnt = 0;
   int fe_cnt = 0;
   int sv0, fe0;

   ps2_keypad #(.FILTER_LEN(8), .TIMEOUT_CYC(300)) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keydown(keydown), .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (scan_valid) sv_cnt++;
      if (frame_err) fe_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      repeat (10) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (20) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] b, input logic bad_par = 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(1'b1);
      repeat (20) @(posedge clk);
   endtask

   task automatic mark;
      @(negedge clk);
      sv0 = sv_cnt;
      fe0 = fe_cnt;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("reset_keydown", keydown, 5'b00000);
      chk("reset_code", scan_code, 8'h00);
      chk("reset_pulses", sv_cnt + fe_cnt, 0);
      send(8'h29);
      chk("jump_make", keydown, 5'b10000);
      chk("jump_code", scan_code, 8'h29);
      mark();
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ps2_data = 1'b1;
      repeat (30) @(negedge clk);
      chk("rst_mid_keydown", keydown, 5'b00000);
      chk("rst_mid_pulses", (sv_cnt - sv0) + (fe_cnt - fe0), 0);
      send(8'h29);
      chk("after_rst_29", keydown, 5'b10000);
      send(8'hF0);
      send(8'h29);
      chk("jump_break", keydown, 5'b00000);
      mark();
      send(8'hE0);
      send(8'h75);
      @(negedge clk);
      chk("up_sv_count", sv_cnt - sv0, 2);
      chk("up_code", scan_code, 8'h75);
      chk("up_make", keydown, 5'b00001);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("up_break", keydown, 5'b00000);
      send(8'h29);
      send(8'h29);
      chk("typematic", keydown, 5'b10000);
      send(8'hF0);
      send(8'h29);
      chk("jump_release", keydown, 5'b00000);
      send(8'hF0);
      send(8'h29);
      chk("break_not_held", keydown, 5'b00000);
      send(8'hE0);
      send(8'h75);
      mark();
      send(8'h29, 1'b1);
      @(negedge clk);
      chk("bad_par_fe", fe_cnt - fe0, 1);
      chk("bad_par_sv", sv_cnt - sv0, 0);
      chk("bad_par_keydown", keydown, 5'b00001);
      send(8'hE0);
      send(8'h29, 1'b1);
      send(8'h75);
      chk("err_clears_ext", keydown, 5'b00001);
      chk("err_code", scan_code, 8'h75);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("up_clear", keydown, 5'b00000);
      mark();
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b1);
      repeat (350) @(negedge clk);
      chk("timeout_fe", fe_cnt - fe0, 1);
      chk("timeout_sv", sv_cnt - sv0, 0);
      send(8'hE0);
      send(8'h6B);
      chk("left_after_timeout", keydown, 5'b00010);
      send(8'hE0);
      send(8'h74);
      chk("left_right", keydown, 5'b00110);
      send(8'hE0);
      send(8'hF0);
      send(8'h6B);
      chk("left_release", keydown, 5'b00100);
      send(8'hE0);
      send(8'hF0);
      send(8'h74);
      chk("right_release", keydown, 5'b00000);
      send(8'h75);
      chk("keypad_unmapped", keydown, 5'b00000);
      mark();
      send(8'h1C);
      @(negedge clk);
      chk("wasd_sv", sv_cnt - sv0, 1);
`ifdef KEYPAD_WASD_EN
      chk("wasd_a", keydown, 5'b00010);
      send(8'hE0);
      send(8'h74);
      chk("wasd_a_right", keydown, 5'b00110);
`else
      chk("wasd_a", keydown, 5'b00000);
      send(8'hE0);
      send(8'h74);
      chk("wasd_a_right", keydown, 5'b00100);
`endif
      send(8'hF0);
      send(8'h1C);
      chk("wasd_a_break", keydown, 5'b00100);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
